mips_hazard_ctrl: RTL and testbench

//  Parametrised hazard/forwarding controller for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB).

---
 rtl/mips_hazard_ctrl.sv | 176 +++++++++++++++++
 tb/tb_mips_hazard_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage MIPS pipeline: EX operand forwarding,
// load-use stall, branch flush, multi-cycle data-memory freeze and saturating event counters.
module mips_hazard_ctrl #(
    parameter int RA_W        = 5,
    parameter int MEM_LAT     = 1,
    parameter int FLUSH_DEPTH = 3,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [RA_W-1:0]  id_rs,
    input  logic [RA_W-1:0]  id_rt,
    input  logic             id_uses_rt,
    input  logic [RA_W-1:0]  ex_rs,
    input  logic [RA_W-1:0]  ex_rt,
    input  logic             ex_mem_read,
    input  logic             ex_reg_write,
    input  logic [RA_W-1:0]  ex_write_reg,
    input  logic             mem_reg_write,
    input  logic [RA_W-1:0]  mem_write_reg,
    input  logic             wb_reg_write,
    input  logic [RA_W-1:0]  wb_write_reg,
    input  logic             mem_access,
    input  logic             branch_taken,
    input  logic             clr_cnt,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_bubble,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             mem_stall,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_MEMWAIT = 1'b1
    } state_t;

    // First MEMWAIT count; the RUN cycle that sees the access already freezes once.
    localparam logic [3:0]       WAIT_INIT = (MEM_LAT > 1) ? 4'(MEM_LAT - 2) : 4'd0;
    localparam logic             MULTI_CYC = (MEM_LAT > 1);
    localparam logic             FLUSH_IDEX = (FLUSH_DEPTH >= 2);
    localparam logic             FLUSH_EXMEM = (FLUSH_DEPTH >= 3);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // EX/MEM result is younger than MEM/WB, so it takes precedence.
    function automatic logic [1:0] fwd_sel(
        input logic            m_wr,
        input logic [RA_W-1:0] m_reg,
        input logic            w_wr,
        input logic [RA_W-1:0] w_reg,
        input logic [RA_W-1:0] src
    );
        logic [1:0] sel;
        if (m_wr && (m_reg != '0) && (m_reg == src)) begin
            sel = 2'b10;
        end else if (w_wr && (w_reg != '0) && (w_reg == src)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    function automatic logic [CNT_W-1:0] sat_next(
        input logic             clr,
        input logic             inc,
        input logic [CNT_W-1:0] cur
    );
        logic [CNT_W-1:0] nxt;
        if (clr) begin
            nxt = '0;
        end else if (inc && (cur != CNT_MAX)) begin
            nxt = cur + CNT_ONE;
        end else begin
            nxt = cur;
        end
        return nxt;
    endfunction

    state_t           state_r, state_nx_s;
    logic [3:0]       wait_cnt_r, wait_cnt_nx_s;
    logic             mem_stall_s;
    logic             lu_s;
    logic             fl_s;
    logic             stall_evt_s;
    logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;

    assign fwd_a = fwd_sel(mem_reg_write, mem_write_reg, wb_reg_write, wb_write_reg, ex_rs);
    assign fwd_b = fwd_sel(mem_reg_write, mem_write_reg, wb_reg_write, wb_write_reg, ex_rt);

    assign lu_s = ex_mem_read && ex_reg_write && (ex_write_reg != '0) &&
                  ((ex_write_reg == id_rs) || (id_uses_rt && (ex_write_reg == id_rt)));
    assign fl_s        = branch_taken && !mem_stall_s;
    assign stall_evt_s = (lu_s && !fl_s) || mem_stall_s;

    // Memory-latency FSM: next state, wait count and freeze request.
    always_comb begin
        state_nx_s    = state_r;
        wait_cnt_nx_s = wait_cnt_r;
        mem_stall_s   = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (mem_access && MULTI_CYC) begin
                    mem_stall_s   = 1'b1;
                    state_nx_s    = ST_MEMWAIT;
                    wait_cnt_nx_s = WAIT_INIT;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_MEMWAIT: begin
                if (wait_cnt_r != 4'd0) begin
                    mem_stall_s   = 1'b1;
                    wait_cnt_nx_s = wait_cnt_r - 4'd1;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            default: begin
                state_nx_s    = ST_RUN;
                wait_cnt_nx_s = 4'd0;
            end
        endcase
    end

    // Pipeline-register controls; freeze beats flush, flush beats load-use.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        if (mem_stall_s) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
        end else if (fl_s) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = FLUSH_IDEX;
            ex_mem_flush = FLUSH_EXMEM;
        end else if (lu_s) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end else begin
            pc_write = 1'b1;
        end
    end

    assign mem_stall = mem_stall_s;
    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;

    // FSM state and saturating statistics counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_RUN;
            wait_cnt_r  <= 4'd0;
            stall_cnt_r <= '0;
            flush_cnt_r <= '0;
        end else begin
            state_r     <= state_nx_s;
            wait_cnt_r  <= wait_cnt_nx_s;
            stall_cnt_r <= sat_next(clr_cnt, stall_evt_s, stall_cnt_r);
            flush_cnt_r <= sat_next(clr_cnt, fl_s, flush_cnt_r);
        end
    end

endmodule

// File: tb/tb_mips_hazard_ctrl.sv
// Self-checking bench for mips_hazard_ctrl: a default instance and one with MEM_LAT=4,
// FLUSH_DEPTH=2, CNT_W=4 share the same stimulus; expected control vectors go through a queue.
module tb_mips_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_write_reg, mem_write_reg, wb_write_reg;
    logic       id_uses_rt, ex_mem_read, ex_reg_write, mem_reg_write, wb_reg_write;
    logic       mem_access, branch_taken, clr_cnt;

    logic [1:0]  fwd_a0, fwd_b0, fwd_a1, fwd_b1;
    logic        pc_write0, if_id_write0, id_ex_bubble0, if_id_flush0, id_ex_flush0, ex_mem_flush0, mem_stall0;
    logic        pc_write1, if_id_write1, id_ex_bubble1, if_id_flush1, id_ex_flush1, ex_mem_flush1, mem_stall1;
    logic [15:0] stall_cnt0, flush_cnt0;
    logic [3:0]  stall_cnt1, flush_cnt1;

    logic [10:0] obs0, obs1;
    logic [10:0] exp_q[$];
    logic [10:0] exp_v;
    int checks = 0;
    int errors = 0;

    // Vector layout: {fwd_a, fwd_b, pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush, ex_mem_flush, mem_stall}
    localparam logic [10:0] V_IDLE  = 11'b0000_110_000_0;
    localparam logic [10:0] V_LU    = 11'b0000_001_000_0;
    localparam logic [10:0] V_STALL = 11'b0000_000_000_1;
    localparam logic [10:0] V_BR2   = 11'b0000_110_110_0;
    localparam logic [10:0] V_BR3   = 11'b0000_110_111_0;

    assign obs0 = {fwd_a0, fwd_b0, pc_write0, if_id_write0, id_ex_bubble0,
                   if_id_flush0, id_ex_flush0, ex_mem_flush0, mem_stall0};
    assign obs1 = {fwd_a1, fwd_b1, pc_write1, if_id_write1, id_ex_bubble1,
                   if_id_flush1, id_ex_flush1, ex_mem_flush1, mem_stall1};

    always #5 clk = ~clk;

    mips_hazard_ctrl dut0 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
        .ex_write_reg(ex_write_reg), .mem_reg_write(mem_reg_write), .mem_write_reg(mem_write_reg),
        .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg), .mem_access(mem_access),
        .branch_taken(branch_taken), .clr_cnt(clr_cnt), .fwd_a(fwd_a0), .fwd_b(fwd_b0),
        .pc_write(pc_write0), .if_id_write(if_id_write0), .id_ex_bubble(id_ex_bubble0),
        .if_id_flush(if_id_flush0), .id_ex_flush(id_ex_flush0), .ex_mem_flush(ex_mem_flush0),
        .mem_stall(mem_stall0), .stall_cnt(stall_cnt0), .flush_cnt(flush_cnt0)
    );

    mips_hazard_ctrl #(.RA_W(5), .MEM_LAT(4), .FLUSH_DEPTH(2), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
        .ex_write_reg(ex_write_reg), .mem_reg_write(mem_reg_write), .mem_write_reg(mem_write_reg),
        .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg), .mem_access(mem_access),
        .branch_taken(branch_taken), .clr_cnt(clr_cnt), .fwd_a(fwd_a1), .fwd_b(fwd_b1),
        .pc_write(pc_write1), .if_id_write(if_id_write1), .id_ex_bubble(id_ex_bubble1),
        .if_id_flush(if_id_flush1), .id_ex_flush(id_ex_flush1), .ex_mem_flush(ex_mem_flush1),
        .mem_stall(mem_stall1), .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1)
    );

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; ex_rs = 5'd0; ex_rt = 5'd0;
        ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_write_reg = 5'd0;
        mem_reg_write = 1'b0; mem_write_reg = 5'd0; wb_reg_write = 1'b0; wb_write_reg = 5'd0;
        mem_access = 1'b0; branch_taken = 1'b0; clr_cnt = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counters();
        step(); idle(); clr_cnt = 1'b1;
        step(); clr_cnt = 1'b0;
    endtask

    task automatic set_lu();
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_write_reg = 5'd5; id_rt = 5'd5; id_uses_rt = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        exp_q.push_back(V_IDLE);
        exp_v = exp_q.pop_front();
        checks++;
        if (obs1 !== exp_v) begin errors++; $display("FAIL reset_vec1: got %b want %b", obs1, exp_v); end
        checks++;
        if (obs0 !== V_IDLE) begin errors++; $display("FAIL reset_vec0: got %b want %b", obs0, V_IDLE); end
        checks++;
        if (stall_cnt1 !== 4'd0 || flush_cnt1 !== 4'd0 || stall_cnt0 !== 16'd0 || flush_cnt0 !== 16'd0) begin
            errors++;
            $display("FAIL reset_cnt: got %0d/%0d/%0d/%0d want 0/0/0/0", stall_cnt1, flush_cnt1, stall_cnt0, flush_cnt0);
        end
        #2 rst = 1'b1;
    endtask

    task automatic test_forwarding();
        logic [3:0] fwd_exp [6] = '{4'b1000, 4'b0100, 4'b0110, 4'b0000, 4'b0001, 4'b0000};
        for (int i = 0; i < 6; i++) begin
            step();
            case (i)
                0: begin
                    mem_reg_write = 1'b1; mem_write_reg = 5'd3; wb_reg_write = 1'b1; wb_write_reg = 5'd3;
                    ex_rs = 5'd3; ex_rt = 5'd7;
                end
                1: mem_write_reg = 5'd0;
                2: mem_write_reg = 5'd7;
                3: begin mem_reg_write = 1'b0; wb_reg_write = 1'b0; end
                4: begin wb_reg_write = 1'b1; wb_write_reg = 5'd7; end
                5: begin mem_reg_write = 1'b1; mem_write_reg = 5'd0; wb_write_reg = 5'd0; ex_rs = 5'd0; ex_rt = 5'd0; end
                default: ;
            endcase
            exp_q.push_back({fwd_exp[i], 7'b110_000_0});
            @(negedge clk);
            exp_v = exp_q.pop_front();
            checks++;
            if (obs1 !== exp_v) begin errors++; $display("FAIL fwd_%0d: got %b want %b", i, obs1, exp_v); end
            checks++;
            if (obs0 !== exp_v) begin errors++; $display("FAIL fwd0_%0d: got %b want %b", i, obs0, exp_v); end
        end
    endtask

    task automatic test_load_use();
        logic [10:0] lu_exp [5] = '{V_LU, V_IDLE, V_IDLE, V_LU, V_IDLE};
        clear_counters();
        for (int i = 0; i < 5; i++) begin
            step();
            case (i)
                0: begin set_lu(); id_rs = 5'd2; end
                1: id_uses_rt = 1'b0;
                2: begin id_uses_rt = 1'b1; ex_write_reg = 5'd0; id_rt = 5'd0; end
                3: begin ex_write_reg = 5'd2; id_uses_rt = 1'b0; id_rt = 5'd9; end
                default: idle();
            endcase
            exp_q.push_back(lu_exp[i]);
            @(negedge clk);
            exp_v = exp_q.pop_front();
            checks++;
            if (obs1 !== exp_v) begin errors++; $display("FAIL lu_%0d: got %b want %b", i, obs1, exp_v); end
            if (i == 1) begin
                checks++;
                if (stall_cnt1 !== 4'd1 || stall_cnt0 !== 16'd1) begin
                    errors++; $display("FAIL lu_cnt1: got %0d/%0d want 1/1", stall_cnt1, stall_cnt0);
                end
            end
        end
        checks++;
        if (stall_cnt1 !== 4'd2) begin errors++; $display("FAIL lu_cnt2: got %0d want 2", stall_cnt1); end
    endtask

    task automatic test_branch();
        clear_counters();
        step();
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_write_reg = 5'd5; id_rs = 5'd5; branch_taken = 1'b1;
        exp_q.push_back(V_BR2);
        @(negedge clk);
        exp_v = exp_q.pop_front();
        checks++;
        if (obs1 !== exp_v) begin errors++; $display("FAIL br_fd2: got %b want %b", obs1, exp_v); end
        checks++;
        if (obs0 !== V_BR3) begin errors++; $display("FAIL br_fd3: got %b want %b", obs0, V_BR3); end
        step(); idle();
        @(negedge clk);
        checks++;
        if (flush_cnt1 !== 4'd1 || stall_cnt1 !== 4'd0 || flush_cnt0 !== 16'd1) begin
            errors++;
            $display("FAIL br_cnt: got fl=%0d st=%0d fl0=%0d want 1/0/1", flush_cnt1, stall_cnt1, flush_cnt0);
        end
    endtask

    task automatic test_mem_stall();
        logic [10:0] ms_exp [5] = '{V_STALL, V_STALL, V_STALL, V_IDLE, V_IDLE};
        clear_counters();
        for (int i = 0; i < 5; i++) begin
            step();
            idle();
            case (i)
                0: mem_access = 1'b1;
                2: branch_taken = 1'b1;
                3: mem_access = 1'b1;
                default: ;
            endcase
            exp_q.push_back(ms_exp[i]);
            @(negedge clk);
            exp_v = exp_q.pop_front();
            checks++;
            if (obs1 !== exp_v) begin errors++; $display("FAIL memst_%0d: got %b want %b", i, obs1, exp_v); end
            if (i == 0) begin
                checks++;
                if (obs0 !== V_IDLE) begin errors++; $display("FAIL memst_lat1: got %b want %b", obs0, V_IDLE); end
            end
        end
        checks++;
        if (stall_cnt1 !== 4'd3 || flush_cnt1 !== 4'd0) begin
            errors++; $display("FAIL memst_cnt: got st=%0d fl=%0d want 3/0", stall_cnt1, flush_cnt1);
        end
    endtask

    task automatic test_reset_midwait();
        step(); idle(); mem_access = 1'b1;
        exp_q.push_back(V_STALL);
        @(negedge clk);
        exp_v = exp_q.pop_front();
        checks++;
        if (obs1 !== exp_v) begin errors++; $display("FAIL rmw_first: got %b want %b", obs1, exp_v); end
        step(); mem_access = 1'b0;
        exp_q.push_back(V_STALL);
        @(negedge clk);
        exp_v = exp_q.pop_front();
        checks++;
        if (obs1 !== exp_v) begin errors++; $display("FAIL rmw_second: got %b want %b", obs1, exp_v); end
        #1 rst = 1'b0;
        #1;
        checks++;
        if (mem_stall1 !== 1'b0 || stall_cnt1 !== 4'd0 || flush_cnt1 !== 4'd0) begin
            errors++;
            $display("FAIL rmw_async: got stall=%b st=%0d fl=%0d want 0/0/0", mem_stall1, stall_cnt1, flush_cnt1);
        end
        #1 rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            idle();
            if (i == 1) mem_access = 1'b1;
            exp_q.push_back((i >= 1 && i <= 3) ? V_STALL : V_IDLE);
            @(negedge clk);
            exp_v = exp_q.pop_front();
            checks++;
            if (obs1 !== exp_v) begin errors++; $display("FAIL rmw_after_%0d: got %b want %b", i, obs1, exp_v); end
        end
    endtask

    task automatic test_saturation();
        clear_counters();
        for (int i = 0; i < 20; i++) begin
            step();
            idle(); set_lu();
            exp_q.push_back(V_LU);
            @(negedge clk);
            exp_v = exp_q.pop_front();
            checks++;
            if (obs1 !== exp_v) begin errors++; $display("FAIL sat_vec_%0d: got %b want %b", i, obs1, exp_v); end
        end
        step(); clr_cnt = 1'b1;
        @(negedge clk);
        checks++;
        if (stall_cnt1 !== 4'd15 || stall_cnt0 !== 16'd20) begin
            errors++; $display("FAIL sat_stall: got %0d/%0d want 15/20", stall_cnt1, stall_cnt0);
        end
        step(); idle();
        @(negedge clk);
        checks++;
        if (stall_cnt1 !== 4'd0 || stall_cnt0 !== 16'd0) begin
            errors++; $display("FAIL sat_clr: got %0d/%0d want 0/0", stall_cnt1, stall_cnt0);
        end
        for (int i = 0; i < 17; i++) begin
            step(); idle(); branch_taken = 1'b1;
        end
        step(); idle();
        @(negedge clk);
        checks++;
        if (flush_cnt1 !== 4'd15 || flush_cnt0 !== 16'd17 || stall_cnt1 !== 4'd0) begin
            errors++;
            $display("FAIL sat_flush: got %0d/%0d st=%0d want 15/17/0", flush_cnt1, flush_cnt0, stall_cnt1);
        end
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch();
        test_mem_stall();
        test_reset_midwait();
        test_saturation();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL sb_drain: got %0d want 0", exp_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
